alsu_pipe: RTL and testbench
============================

Name: alsu_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle ALSU.
- Performs OR/XOR (with optional reduction), ADD, signed MULT, SHIFT and ROTATE on WIDTH-bit signed operands.
- Carries in_valid/in_ready and out_valid/out_ready handshakes so it can sit between stream stages with backpressure.
- Adds an LED blink state machine and a saturating error counter for invalid operations.

Parameters:
- WIDTH, 3, operand width of A and B (signed).
- OUT_W, 2*WIDTH, result width; must be >= 2*WIDTH.
- LED_W, 16, width of the leds port.
- FULL_ADDER, 1, 1 = ADD uses cin; 0 = cin ignored.
- PRIORITY_A, 1, 1 = A wins when both bypass_A and bypass_B are set, and red_op_A wins over red_op_B; 0 = B wins in both cases.
- BLINK_DIV, 4, number of cycles between LED toggles while blinking (>= 1).
- CNT_W, 8, width of err_cnt.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request this cycle.
- opcode  in  3  0 OR, 1 XOR, 2 ADD, 3 MULT, 4 SHIFT, 5 ROTATE, 6/7 invalid.
- A  in  WIDTH  signed operand.
- B  in  WIDTH  signed operand.
- cin  in  1  carry-in for ADD.
- red_op_A  in  1  reduction on A (OR/XOR only).
- red_op_B  in  1  reduction on B (OR/XOR only).
- bypass_A  in  1  pass A to out.
- bypass_B  in  1  pass B to out.
- direction  in  1  1 = left, 0 = right (SHIFT/ROTATE).
- serial_in  in  1  fill bit for SHIFT.
- out_valid  out  1  out holds a result not yet consumed.
- out_ready  in  1  downstream accepts the result.
- out  out  OUT_W  signed result register.
- leds  out  LED_W  error indicator.
- err_cnt  out  CNT_W  saturating count of invalid requests.

Behaviour:
- Reset (async, immediate):
  - out=0, out_valid=0, leds=0, err_cnt=0.
  - Stage-1 valid=0; LED FSM = IDLE; blink counter = 0.
  - in_ready=0 while rst is high.
- Pipeline: S1 input register, then S2 compute/output register.
  - Accept when in_valid && in_ready.
  - Result appears at out with out_valid=1 two cycles after accept when there is no stall.
- Handshake:
  - s2_free = !out_valid || out_ready.
  - in_ready = !s1_valid || s2_free.
  - S1 advances into S2 only when s2_free.
  - out and out_valid hold stable while out_valid && !out_ready.
  - Accept and consume in the same cycle sustain one result per cycle.
- Invalid request:
  - opcode 6 or 7, or (red_op_A || red_op_B) with opcode not OR/XOR.
  - Invalid is checked first; bypass does not override it.
  - Result out=0 (out_valid still asserted).
  - err_cnt += 1, saturating at all-ones.
- Priority for valid requests:
  - bypass (A or B per PRIORITY_A when both set) > opcode.
  - Bypassed operand is sign-extended to OUT_W.
- Operation results:
  - OR/XOR: reduction (per PRIORITY_A if both set) gives a 1-bit result, zero-extended. Otherwise bitwise A op B at WIDTH bits, sign-extended.
  - ADD: A+B(+cin when FULL_ADDER=1), signed, sign-extended; no overflow possible since OUT_W > WIDTH.
  - MULT: full signed A*B, sign-extended.
  - SHIFT: operates on the current out register by one bit.
    - direction=1: {out[OUT_W-2:0], serial_in}.
    - direction=0: {serial_in, out[OUT_W-1:1]}.
  - ROTATE: same as SHIFT with the wrapped bit in place of serial_in.
  - "Current out" is the value in out when the request enters S2, including a result just consumed in that same cycle.
- LED FSM (IDLE/BLINK), updated when a result enters S2:
  - Invalid result: go to BLINK, leds=all ones, blink counter cleared. This also applies when already in BLINK (restart).
  - Valid result: go to IDLE, leds=0.
  - In BLINK: every BLINK_DIV cycles leds inverts; counts independently of stalls.
- Reset mid-operation discards S1/S2 contents; no result emerges.

Test Plan:
- WIDTH=3, A=-3, B=3, MULT, out_ready=1 -> out=6'b110111 (-9), out_valid exactly 2 cycles after accept.
- ADD, A=3, B=2, cin=1 (FULL_ADDER=1) -> out=6; same with FULL_ADDER=0 -> out=5. Both bypass bits set, A=-2, B=1, PRIORITY_A=1 -> out=-2.
- From out=6'b000101: SHIFT direction=1 serial_in=1 -> 6'b001011; then ROTATE direction=0 -> 6'b100101.
- opcode=6, then red_op_A with ADD -> both give out=0 and err_cnt=2. leds=16'hFFFF, then 16'h0000 after BLINK_DIV cycles, toggling thereafter. A following valid OR -> leds=0.
- out_ready held 0 while 3 requests are offered -> 2 accepted, then in_ready=0 and out stable. Releasing out_ready -> results drain in order, one per cycle.
- Assert rst with both stages full -> out_valid=0, out=0, leds=0 immediately; no stale result after release.

Source files
------------

// File: rtl/alsu_pipe.sv
// Two-stage pipelined ALSU (S1 input register, S2 compute/output register) with
// valid/ready handshakes, an LED blink indicator and a saturating invalid-request counter.
module alsu_pipe #(
    parameter int WIDTH      = 3,
    parameter int OUT_W      = 2*WIDTH,
    parameter int LED_W      = 16,
    parameter int FULL_ADDER = 1,
    parameter int PRIORITY_A = 1,
    parameter int BLINK_DIV  = 4,
    parameter int CNT_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              opcode,
    input  logic signed [WIDTH-1:0] A,
    input  logic signed [WIDTH-1:0] B,
    input  logic                    cin,
    input  logic                    red_op_A,
    input  logic                    red_op_B,
    input  logic                    bypass_A,
    input  logic                    bypass_B,
    input  logic                    direction,
    input  logic                    serial_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out,
    output logic [LED_W-1:0]        leds,
    output logic [CNT_W-1:0]        err_cnt
);

    localparam logic [2:0] OP_OR    = 3'd0;
    localparam logic [2:0] OP_XOR   = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_MULT  = 3'd3;
    localparam logic [2:0] OP_SHIFT = 3'd4;
    localparam logic [2:0] OP_ROT   = 3'd5;
    localparam int         BCW      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    typedef struct packed {
        logic [2:0]       opcode;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic             red_a;
        logic             red_b;
        logic             byp_a;
        logic             byp_b;
        logic             dir;
        logic             ser;
    } req_t;

    typedef enum logic {LED_IDLE, LED_BLINK} led_state_e;

    logic                    s1_valid_q, s1_valid_d;
    req_t                    s1_q, s1_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0] out_q, out_d;
    logic [CNT_W-1:0]        err_cnt_q, err_cnt_d;
    led_state_e              led_state_q, led_state_d;
    logic [LED_W-1:0]        leds_q, leds_d;
    logic [BCW-1:0]          blink_cnt_q, blink_cnt_d;

    logic s2_free, accept, advance, s1_invalid;

    logic signed [WIDTH-1:0]   a_s, b_s, bw, byp_op, red_src;
    logic signed [WIDTH:0]     sum;
    logic signed [2*WIDTH-1:0] prod;
    logic                      red_bit, cin_eff;
    logic signed [OUT_W-1:0]   res;

    // S1 may refill in the same cycle it drains into S2.
    assign s2_free  = !out_valid_q || out_ready;
    assign in_ready = !rst && (!s1_valid_q || s2_free);
    assign accept   = in_valid && in_ready;
    assign advance  = s1_valid_q && s2_free;

    always_comb begin
        a_s     = $signed(s1_q.a);
        b_s     = $signed(s1_q.b);
        cin_eff = (FULL_ADDER != 0) ? s1_q.cin : 1'b0;
        sum     = (WIDTH+1)'(a_s) + (WIDTH+1)'(b_s) + (WIDTH+1)'({1'b0, cin_eff});
        prod    = (2*WIDTH)'(a_s) * (2*WIDTH)'(b_s);

        if (s1_q.red_a && s1_q.red_b) red_src = (PRIORITY_A != 0) ? a_s : b_s;
        else if (s1_q.red_a)          red_src = a_s;
        else                          red_src = b_s;
        red_bit = (s1_q.opcode == OP_OR) ? |red_src : ^red_src;
        bw      = (s1_q.opcode == OP_OR) ? (a_s | b_s) : (a_s ^ b_s);

        if (s1_q.byp_a && s1_q.byp_b) byp_op = (PRIORITY_A != 0) ? a_s : b_s;
        else if (s1_q.byp_a)          byp_op = a_s;
        else                          byp_op = b_s;

        // Reduction flags are only meaningful for OR/XOR; anything else is rejected.
        s1_invalid = (s1_q.opcode > OP_ROT) ||
                     ((s1_q.red_a || s1_q.red_b) &&
                      (s1_q.opcode != OP_OR) && (s1_q.opcode != OP_XOR));

        res = '0;
        if (s1_invalid) begin
            res = '0;
        end else if (s1_q.byp_a || s1_q.byp_b) begin
            res = OUT_W'(byp_op);
        end else begin
            case (s1_q.opcode)
                OP_OR, OP_XOR: begin
                    if (s1_q.red_a || s1_q.red_b) res = OUT_W'(red_bit);
                    else                          res = OUT_W'(bw);
                end
                OP_ADD:   res = OUT_W'(sum);
                OP_MULT:  res = OUT_W'(prod);
                OP_SHIFT: res = s1_q.dir ? {out_q[OUT_W-2:0], s1_q.ser}
                                         : {s1_q.ser, out_q[OUT_W-1:1]};
                OP_ROT:   res = s1_q.dir ? {out_q[OUT_W-2:0], out_q[OUT_W-1]}
                                         : {out_q[0], out_q[OUT_W-1:1]};
                default:  res = '0;
            endcase
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_d        = s1_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        err_cnt_d   = err_cnt_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_d       = '{opcode: opcode, a: A, b: B, cin: cin,
                           red_a: red_op_A, red_b: red_op_B,
                           byp_a: bypass_A, byp_b: bypass_B,
                           dir: direction, ser: serial_in};
        end else if (advance) begin
            s1_valid_d = 1'b0;
        end

        // out keeps its value after consumption so SHIFT/ROTATE can chain on it.
        if (advance) begin
            out_d       = res;
            out_valid_d = 1'b1;
            if (s1_invalid && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        led_state_d = led_state_q;
        leds_d      = leds_q;
        blink_cnt_d = blink_cnt_q;

        if (advance) begin
            blink_cnt_d = '0;
            if (s1_invalid) begin
                led_state_d = LED_BLINK;
                leds_d      = '1;
            end else begin
                led_state_d = LED_IDLE;
                leds_d      = '0;
            end
        end else if (led_state_q == LED_BLINK) begin
            // Free-running while blinking; stalls do not pause it.
            if (blink_cnt_q == BCW'(BLINK_DIV - 1)) begin
                blink_cnt_d = '0;
                leds_d      = ~leds_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            err_cnt_q   <= '0;
            led_state_q <= LED_IDLE;
            leds_q      <= '0;
            blink_cnt_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_q        <= s1_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            err_cnt_q   <= err_cnt_d;
            led_state_q <= led_state_d;
            leds_q      <= leds_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign leds      = leds_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_alsu_pipe.sv
// Directed bench for alsu_pipe: two instances (FULL_ADDER/PRIORITY_A = 1/1 and 0/0)
// share stimulus; a reference model fills per-instance queues that are drained on output.
module tb_alsu_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, in_valid, out_ready;
    logic [2:0]        opcode;
    logic signed [2:0] A, B;
    logic              cin, red_op_A, red_op_B, bypass_A, bypass_B, direction, serial_in;

    logic        in_ready_a, in_ready_b, out_valid_a, out_valid_b;
    logic [5:0]  out_a, out_b;
    logic [15:0] leds_a, leds_b;
    logic [7:0]  err_a, err_b;

    int n_cmp = 0;
    int n_bad = 0;
    logic [5:0] q_a[$];
    logic [5:0] q_b[$];
    logic [5:0] cur_a = '0;
    logic [5:0] cur_b = '0;

    alsu_pipe #(.WIDTH(3), .OUT_W(6), .LED_W(16), .FULL_ADDER(1), .PRIORITY_A(1),
                .BLINK_DIV(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .opcode(opcode), .A(A), .B(B), .cin(cin), .red_op_A(red_op_A), .red_op_B(red_op_B),
        .bypass_A(bypass_A), .bypass_B(bypass_B), .direction(direction), .serial_in(serial_in),
        .out_valid(out_valid_a), .out_ready(out_ready), .out(out_a), .leds(leds_a), .err_cnt(err_a));

    alsu_pipe #(.WIDTH(3), .OUT_W(6), .LED_W(16), .FULL_ADDER(0), .PRIORITY_A(0),
                .BLINK_DIV(4), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .opcode(opcode), .A(A), .B(B), .cin(cin), .red_op_A(red_op_A), .red_op_B(red_op_B),
        .bypass_A(bypass_A), .bypass_B(bypass_B), .direction(direction), .serial_in(serial_in),
        .out_valid(out_valid_b), .out_ready(out_ready), .out(out_b), .leds(leds_b), .err_cnt(err_b));

    function automatic logic [5:0] model(input logic [2:0] op, input logic signed [2:0] a,
                                         input logic signed [2:0] b, input logic ci,
                                         input logic ra, input logic rb, input logic ba,
                                         input logic bb, input logic dr, input logic si,
                                         input logic [5:0] cur, input bit fa, input bit pa);
        int r;
        logic signed [2:0] pick;
        r = 0;
        if (op >= 3'd6 || ((ra || rb) && op > 3'd1)) return 6'd0;
        if (ba && bb)  r = int'(pa ? a : b);
        else if (ba)   r = int'(a);
        else if (bb)   r = int'(b);
        else begin
            case (op)
                3'd0, 3'd1: begin
                    if (ra || rb) begin
                        pick = (ra && rb) ? (pa ? a : b) : (ra ? a : b);
                        r = (op == 3'd0) ? int'(|pick) : int'(^pick);
                    end else begin
                        pick = (op == 3'd0) ? (a | b) : (a ^ b);
                        r = int'(pick);
                    end
                end
                3'd2:    r = int'(a) + int'(b) + (fa ? int'(ci) : 0);
                3'd3:    r = int'(a) * int'(b);
                3'd4:    r = dr ? int'({cur[4:0], si}) : int'({si, cur[5:1]});
                3'd5:    r = dr ? int'({cur[4:0], cur[5]}) : int'({cur[0], cur[5:1]});
                default: r = 0;
            endcase
        end
        return r[5:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: score outputs and record accepts at negedge, then step past posedge.
    task automatic tick();
        logic [5:0] e;
        @(negedge clk);
        if (out_valid_a && out_ready) begin
            if (q_a.size() == 0) chk("a_spurious_out", 32'(out_valid_a), 32'd0);
            else begin e = q_a.pop_front(); chk("a_out", 32'(out_a), 32'(e)); end
        end
        if (out_valid_b && out_ready) begin
            if (q_b.size() == 0) chk("b_spurious_out", 32'(out_valid_b), 32'd0);
            else begin e = q_b.pop_front(); chk("b_out", 32'(out_b), 32'(e)); end
        end
        if (in_valid && in_ready_a) begin
            e = model(opcode, A, B, cin, red_op_A, red_op_B, bypass_A, bypass_B,
                      direction, serial_in, cur_a, 1'b1, 1'b1);
            cur_a = e;
            q_a.push_back(e);
        end
        if (in_valid && in_ready_b) begin
            e = model(opcode, A, B, cin, red_op_A, red_op_B, bypass_A, bypass_B,
                      direction, serial_in, cur_b, 1'b0, 1'b0);
            cur_b = e;
            q_b.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                         input logic ci, input logic ra, input logic rb, input logic ba,
                         input logic bb, input logic dr, input logic si);
        in_valid = 1'b1; opcode = op; A = a; B = b; cin = ci;
        red_op_A = ra; red_op_B = rb; bypass_A = ba; bypass_B = bb;
        direction = dr; serial_in = si;
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                         input logic ci, input logic ra, input logic rb, input logic ba,
                         input logic bb, input logic dr, input logic si);
        drive(op, a, b, ci, ra, rb, ba, bb, dr, si);
        tick();
    endtask

    initial begin
        rst = 1'b1; out_ready = 1'b1;
        drive(3'd0, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid_a), 32'd0);
        chk("rst_out", 32'(out_a), 32'd0);
        chk("rst_leds", 32'(leds_a), 32'd0);
        chk("rst_err_cnt", 32'(err_a), 32'd0);
        chk("rst_in_ready", 32'(in_ready_a), 32'd0);
        rst = 1'b0;

        // MULT -3 * 3 with latency check
        issue(3'd3, 3'b101, 3'b011, 0, 0, 0, 0, 0, 0, 0);
        in_valid = 1'b0;
        chk("mult_lat_s1", 32'(out_valid_a), 32'd0);
        tick();
        chk("mult_lat_s2", 32'(out_valid_a), 32'd1);
        chk("mult_val", 32'(out_a), 32'h37);

        // back-to-back stream of arithmetic/logic ops
        issue(3'd2, 3'b011, 3'b010, 1, 0, 0, 0, 0, 0, 0);   // ADD 3+2+cin
        issue(3'd2, 3'b110, 3'b001, 0, 0, 0, 1, 1, 0, 0);   // both bypass
        issue(3'd2, 3'b011, 3'b010, 0, 0, 0, 0, 0, 0, 0);   // -> 5
        issue(3'd4, 3'b000, 3'b000, 0, 0, 0, 0, 0, 1, 1);   // SHIFT left, fill 1
        issue(3'd5, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0);   // ROTATE right
        issue(3'd1, 3'b011, 3'b001, 0, 1, 1, 0, 0, 0, 0);   // XOR reduce, both flags
        issue(3'd0, 3'b100, 3'b001, 0, 0, 0, 0, 0, 0, 0);   // OR bitwise
        issue(3'd1, 3'b011, 3'b111, 0, 0, 0, 0, 0, 0, 0);   // XOR bitwise
        issue(3'd0, 3'b000, 3'b010, 0, 0, 1, 0, 0, 0, 0);   // OR reduce B
        in_valid = 1'b0;
        repeat (3) tick();

        // invalid requests and LED blinking
        issue(3'd6, 3'b011, 3'b001, 0, 0, 0, 1, 0, 0, 0);
        issue(3'd2, 3'b011, 3'b001, 0, 1, 0, 0, 0, 0, 0);
        in_valid = 1'b0;
        tick();
        chk("inv_err_cnt_a", 32'(err_a), 32'd2);
        chk("inv_err_cnt_b", 32'(err_b), 32'd2);
        chk("inv_leds_on", 32'(leds_a), 32'hFFFF);
        repeat (3) tick();
        chk("blink_hold", 32'(leds_a), 32'hFFFF);
        tick();
        chk("blink_off", 32'(leds_a), 32'h0000);
        repeat (3) tick();
        chk("blink_hold_off", 32'(leds_a), 32'h0000);
        tick();
        chk("blink_on_again", 32'(leds_b), 32'hFFFF);
        issue(3'd0, 3'b001, 3'b010, 0, 0, 0, 0, 0, 0, 0);
        in_valid = 1'b0;
        tick();
        chk("valid_clears_leds", 32'(leds_a), 32'h0000);
        chk("valid_keeps_err", 32'(err_a), 32'd2);
        repeat (2) tick();

        // backpressure: two accepted, third held off
        out_ready = 1'b0;
        issue(3'd2, 3'b001, 3'b001, 0, 0, 0, 0, 0, 0, 0);
        issue(3'd2, 3'b001, 3'b010, 0, 0, 0, 0, 0, 0, 0);
        drive(3'd2, 3'b010, 3'b010, 0, 0, 0, 0, 0, 0, 0);
        chk("bp_in_ready", 32'(in_ready_a), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_in_ready_hold", 32'(in_ready_a), 32'd0);
            chk("bp_out_valid", 32'(out_valid_a), 32'd1);
            chk("bp_out_stable", 32'(out_a), 32'd2);
        end
        chk("bp_accepted", 32'(q_a.size()), 32'd2);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("drain_1", 32'(out_a), 32'd3);
        tick();
        chk("drain_2", 32'(out_a), 32'd4);
        chk("drain_2_valid", 32'(out_valid_a), 32'd1);
        tick();
        chk("drain_empty", 32'(out_valid_a), 32'd0);

        // reset with both stages occupied
        out_ready = 1'b0;
        issue(3'd7, 3'b001, 3'b001, 0, 0, 0, 0, 0, 0, 0);
        issue(3'd2, 3'b001, 3'b001, 0, 0, 0, 0, 0, 0, 0);
        in_valid = 1'b0;
        chk("pre_rst_leds", 32'(leds_a), 32'hFFFF);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid_a), 32'd0);
        chk("mid_rst_out", 32'(out_a), 32'd0);
        chk("mid_rst_leds", 32'(leds_a), 32'd0);
        chk("mid_rst_err", 32'(err_a), 32'd0);
        q_a.delete(); q_b.delete();
        cur_a = '0; cur_b = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        chk("post_rst_no_stale", 32'(out_valid_a), 32'd0);
        chk("q_a_empty", 32'(q_a.size()), 32'd0);
        chk("q_b_empty", 32'(q_b.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
